// File: rtl/wb_arbiter.sv
// Write-back arbiter: single-cycle ALU results take priority over queued multi-cycle
// results, which drain in idle ALU slots; newer ALU writes squash stale queued writes.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_addr,
  input  logic [31:0]                   alu_data,
  input  logic                          ext_valid,
  output logic                          ext_ready,
  input  logic [4:0]                    ext_addr,
  input  logic [31:0]                   ext_data,
  output logic [31:0]                   write_result,
  output logic [4:0]                    write_addr,
  output logic                          register_write,
  output logic                          pending,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic [31:0]           write_result_q, write_result_d;
  logic [4:0]            write_addr_q, write_addr_d;
  logic                  register_write_q, register_write_d;
  logic                  alu_eff, push, pop;

  assign ext_ready      = !reset && (count_q != FULL);
  assign alu_eff        = alu_valid && (alu_addr != 5'd0);
  assign push           = ext_valid && ext_ready && (ext_addr != 5'd0);
  assign pop            = !alu_eff && (count_q != '0);

  assign write_result   = write_result_q;
  assign write_addr     = write_addr_q;
  assign register_write = register_write_q;
  assign level          = count_q;
  assign pending        = (count_q != '0);

  always_comb begin
    live_d           = live_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    write_result_d   = write_result_q;
    write_addr_d     = write_addr_q;
    register_write_d = 1'b0;

    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_eff && (addr_q[AW'(i)] == alu_addr)) live_d[AW'(i)] = 1'b0;
    end
    // Push is applied after squash so a same-cycle enqueue stays live (it is younger).
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    if (alu_eff) begin
      register_write_d = 1'b1;
      write_addr_d     = alu_addr;
      write_result_d   = alu_data;
    end else if (pop) begin
      register_write_d = live_q[rd_ptr_q];
      write_addr_d     = addr_q[rd_ptr_q];
      write_result_d   = data_q[rd_ptr_q];
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q           <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      write_result_q   <= '0;
      write_addr_q     <= '0;
      register_write_q <= 1'b0;
    end else begin
      live_q           <= live_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      write_result_q   <= write_result_d;
      write_addr_q     <= write_addr_d;
      register_write_q <= register_write_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count and live bits.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= ext_addr;
      data_q[wr_ptr_q] <= ext_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_addr;
  logic [31:0] ext_data;
  logic [31:0] write_result;
  logic [4:0]  write_addr;
  logic        register_write;
  logic        pending;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr), .ext_data(ext_data),
    .write_result(write_result), .write_addr(write_addr), .register_write(register_write),
    .pending(pending), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ext_valid = 1'b0; ext_addr = '0; ext_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++;
    if ({register_write, write_addr, write_result} !== {1'b0, 5'd0, 32'd0}) begin
      bad++; $display("FAIL reset_outputs: got we=%b a=%0d d=%h want 0 0 0", register_write, write_addr, write_result);
    end
    total++;
    if ({level, pending, ext_ready} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_status: got level=%0d pending=%b ready=%b want 0 0 0", level, pending, ext_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (ext_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %b want 1", ext_ready);
    end
  endtask

  task automatic test_alu_priority();
    ext_valid = 1'b1; ext_addr = 5'd5; ext_data = 32'hAAAA0000;
    tick();
    ext_valid = 1'b0;
    total++;
    if ({register_write, level, pending} !== {1'b0, 3'd1, 1'b1}) begin
      bad++; $display("FAIL prio_enqueue: got we=%b level=%0d pending=%b want 0 1 1", register_write, level, pending);
    end
    for (int unsigned k = 1; k <= 3; k++) begin
      alu_valid = 1'b1; alu_addr = 5'(k); alu_data = 32'h1000 + k;
      tick();
      total++;
      if ({register_write, write_addr, write_result, level} !== {1'b1, 5'(k), 32'h1000 + k, 3'd1}) begin
        bad++; $display("FAIL prio_alu%0d: got we=%b a=%0d d=%h level=%0d want 1 %0d %h 1",
                        k, register_write, write_addr, write_result, level, k, 32'h1000 + k);
      end
    end
    alu_valid = 1'b0;
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd5, 32'hAAAA0000, 3'd0}) begin
      bad++; $display("FAIL prio_drain: got we=%b a=%0d d=%h level=%0d want 1 5 aaaa0000 0",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result} !== {1'b0, 5'd5, 32'hAAAA0000}) begin
      bad++; $display("FAIL idle_hold: got we=%b a=%0d d=%h want 0 5 aaaa0000", register_write, write_addr, write_result);
    end
  endtask

  task automatic test_squash();
    ext_valid = 1'b1; ext_addr = 5'd7; ext_data = 32'h11111111;
    tick();
    ext_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h22222222;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd7, 32'h22222222, 3'd1}) begin
      bad++; $display("FAIL squash_alu: got we=%b a=%0d d=%h level=%0d want 1 7 22222222 1",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b0, 5'd7, 32'h11111111, 3'd0}) begin
      bad++; $display("FAIL squash_dead_pop: got we=%b a=%0d d=%h level=%0d want 0 7 11111111 0",
                      register_write, write_addr, write_result, level);
    end
  endtask

  task automatic test_same_cycle();
    ext_valid = 1'b1; ext_addr = 5'd9; ext_data = 32'hB;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hA;
    tick();
    idle_inputs();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd9, 32'hA, 3'd1}) begin
      bad++; $display("FAIL same_alu: got we=%b a=%0d d=%h level=%0d want 1 9 a 1",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd9, 32'hB, 3'd0}) begin
      bad++; $display("FAIL same_ext_live: got we=%b a=%0d d=%h level=%0d want 1 9 b 0",
                      register_write, write_addr, write_result, level);
    end
  endtask

  task automatic test_full_backpressure();
    for (int unsigned k = 0; k < 4; k++) begin
      ext_valid = 1'b1; ext_addr = 5'(20 + k); ext_data = 32'hC0 + k;
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h100 + k;
      tick();
      total++;
      if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd1, 32'h100 + k, 3'(k + 1)}) begin
        bad++; $display("FAIL full_fill%0d: got we=%b a=%0d d=%h level=%0d want 1 1 %h %0d",
                        k, register_write, write_addr, write_result, level, 32'h100 + k, k + 1);
      end
    end
    total++;
    if ({ext_ready, level, pending} !== {1'b0, 3'd4, 1'b1}) begin
      bad++; $display("FAIL full_status: got ready=%b level=%0d pending=%b want 0 4 1", ext_ready, level, pending);
    end
    ext_addr = 5'd25; ext_data = 32'hC5; alu_data = 32'h200;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({ext_ready, level} !== {1'b0, 3'd4}) begin
      bad++; $display("FAIL full_hold: got ready=%b level=%0d want 0 4", ext_ready, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level, ext_ready} !== {1'b1, 5'd20, 32'hC0, 3'd3, 1'b1}) begin
      bad++; $display("FAIL full_first_pop: got we=%b a=%0d d=%h level=%0d ready=%b want 1 20 c0 3 1",
                      register_write, write_addr, write_result, level, ext_ready);
    end
    tick();
    ext_valid = 1'b0;
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd21, 32'hC1, 3'd3}) begin
      bad++; $display("FAIL full_push_pop: got we=%b a=%0d d=%h level=%0d want 1 21 c1 3",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd22, 32'hC2, 3'd2}) begin
      bad++; $display("FAIL full_drain22: got we=%b a=%0d d=%h level=%0d want 1 22 c2 2",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd23, 32'hC3, 3'd1}) begin
      bad++; $display("FAIL full_drain23: got we=%b a=%0d d=%h level=%0d want 1 23 c3 1",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result, level, pending} !== {1'b1, 5'd25, 32'hC5, 3'd0, 1'b0}) begin
      bad++; $display("FAIL full_drain25: got we=%b a=%0d d=%h level=%0d pending=%b want 1 25 c5 0 0",
                      register_write, write_addr, write_result, level, pending);
    end
  endtask

  task automatic test_zero_addr();
    ext_valid = 1'b1; ext_addr = 5'd12; ext_data = 32'h1234;
    tick();
    ext_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    total++;
    if ({register_write, write_addr, write_result, level} !== {1'b1, 5'd12, 32'h1234, 3'd0}) begin
      bad++; $display("FAIL zero_alu_drain: got we=%b a=%0d d=%h level=%0d want 1 12 1234 0",
                      register_write, write_addr, write_result, level);
    end
    tick();
    total++;
    if ({register_write, write_addr, write_result} !== {1'b0, 5'd12, 32'h1234}) begin
      bad++; $display("FAIL zero_alu_nowrite: got we=%b a=%0d d=%h want 0 12 1234", register_write, write_addr, write_result);
    end
    alu_valid = 1'b0;
    ext_valid = 1'b1; ext_addr = 5'd0; ext_data = 32'h5555;
    #1;
    total++;
    if (ext_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ext_ready: got %b want 1", ext_ready);
    end
    tick();
    ext_valid = 1'b0;
    total++;
    if ({level, pending, register_write} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL zero_ext_drop: got level=%0d pending=%b we=%b want 0 0 0", level, pending, register_write);
    end
    tick();
    total++;
    if (register_write !== 1'b0) begin
      bad++; $display("FAIL zero_ext_nowrite: got we=%b want 0", register_write);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int unsigned k = 0; k < 2; k++) begin
      ext_valid = 1'b1; ext_addr = 5'(14 + k); ext_data = 32'hD0 + k;
      alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h300 + k;
      tick();
    end
    idle_inputs();
    total++;
    if (level !== 3'd2) begin
      bad++; $display("FAIL midrst_fill: got level=%0d want 2", level);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({register_write, level, pending, write_addr} !== {1'b0, 3'd0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL midrst_reset: got we=%b level=%0d pending=%b a=%0d want 0 0 0 0",
                      register_write, level, pending, write_addr);
    end
    tick();
    total++;
    if ({register_write, level} !== {1'b0, 3'd0}) begin
      bad++; $display("FAIL midrst_after: got we=%b level=%0d want 0 0", register_write, level);
    end
  endtask

  initial begin
    test_reset();
    test_alu_priority();
    test_squash();
    test_same_cycle();
    test_full_backpressure();
    test_zero_addr();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the pipelined MIPS core. Merges the single-cycle ALU result path with results from multi-cycle units (load/multiply/divide) and drives the decode stage's single register-file write port (`write_result`, `write_addr`, `register_write`). Multi-cycle results are buffered in a small FIFO and drained in idle ALU slots. Newer ALU writes squash stale queued writes to the same register.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, secondary-result queue depth; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, never back-pressured.
- `alu_addr`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ext_valid`  in  1  multi-cycle unit offers a result.
- `ext_ready`  out  1  arbiter can accept; transfer when `ext_valid && ext_ready`.
- `ext_addr`  in  5  multi-cycle destination register.
- `ext_data`  in  32  multi-cycle result.
- `write_result`  out  32  registered write data to register file.
- `write_addr`  out  5  registered write address.
- `register_write`  out  1  registered write enable.
- `pending`  out  1  FIFO non-empty.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- FIFO entry = {addr[4:0], data[31:0], live}. Circular buffer with read/write pointers and an occupancy count.
- `ext_ready = !reset && (level != FIFO_DEPTH)`. This is combinational from registered count only.
- Accepted ext transfer with `ext_addr == 0`: handshake completes, nothing enqueued.
- Accepted ext transfer with nonzero addr: enqueue at tail with `live = 1`.
- ALU request is effective when `alu_valid && alu_addr != 0`. A zero-address ALU request is treated as no request.
- Per-cycle output selection, priority order:
  1. Effective ALU request: output `{1, alu_addr, alu_data}`. FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop head. Output `{head.live, head.addr, head.data}`. A dead head consumes the slot with `register_write = 0`.
  3. Otherwise: `register_write = 0`. `write_addr` and `write_result` hold their previous values.
- Squash: on an effective ALU request, every stored entry with `addr == alu_addr` gets `live` cleared at the same edge. This prevents an older queued result from overwriting a newer ALU value.
- An entry enqueued in the same cycle as a matching ALU request is NOT squashed; the ext result is considered younger.
- Simultaneous push and pop: allowed, `level` unchanged. Push is impossible when full because `ext_ready` is low.
- Squash and pop in the same cycle cannot coincide, because pop only happens without an ALU request.

## Timing
- Reset (synchronous): `register_write = 0`, `write_addr = 0`, `write_result = 0`, pointers = 0, `level = 0`, `pending = 0`, all `live = 0`. `ext_ready = 0` while `reset` is high.
- ALU path latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N; the register file commits at edge N+1.
- FIFO path minimum latency: push at edge N, earliest pop at edge N+1 if that cycle has no effective ALU request.
- Throughput: one register write per cycle. The FIFO drains at one entry per ALU-idle cycle.
- Reset asserted mid-drain: queued entries are discarded. No write is issued in the cycle after the reset edge.
- `level` and `pending` reflect state after the most recent edge.

## Test plan
- Reset then idle: hold `reset` 2 cycles → all outputs 0, `ext_ready` 0 during reset and 1 the cycle after.
- ALU priority: enqueue ext {r5, 0xAAAA0000}, then 3 consecutive ALU writes {r1,r2,r3} → outputs r1, r2, r3 on successive cycles; then r5 = 0xAAAA0000 one cycle after the ALU stops; `level` goes 1 → 0.
- Squash: enqueue ext {r7, 0x11111111}; next cycle ALU {r7, 0x22222222}; next cycle idle → output r7 = 0x22222222 with `register_write = 1`, then a pop with `register_write = 0`.
- Same-cycle push and ALU to the same register: ext {r9, 0xB} and ALU {r9, 0xA} on the same edge → r9 = 0xA written first, then r9 = 0xB written (live).
- Full and back-pressure: `FIFO_DEPTH = 4`, 4 ext pushes with ALU busy → `ext_ready = 0`, `level = 4`; a 5th `ext_valid` is held until 1 idle cycle pops the head; FIFO order is preserved on drain.
- Zero-address handling: ALU {r0, 0xFFFFFFFF} with one entry queued → FIFO drains that cycle and no write to r0 occurs. Ext {r0, x} is accepted and `level` stays unchanged.
